// File: rtl/fpu_scheduler.sv
// fpu_scheduler
//   Sequences the multi-cycle FPU units for the core controller. A one-cycle
//   go request with a 4-bit fpucontrol opcode selects a unit. The scheduler
//   then pulses start, counts the unit's fixed latency and strobes res_we.
//   A one-cycle valid follows, and the controller waits on it before advancing.
//
// Ports
//   clk         in   1  clock, rising edge
//   rstn        in   1  asynchronous reset, active low
//   go          in   1  request, sampled only in IDLE
//   fpucontrol  in   4  opcode, sampled with go
//   abort       in   1  synchronous cancel of the op in flight
//   start       out  1  one-cycle start pulse to the selected unit
//   unit_sel    out  3  0 addsub,1 mul,2 div,3 sqrt,4 cvt,5 cmp,6 sgn
//   res_we      out  1  one-cycle result-register write enable
//   valid       out  1  one-cycle completion pulse
//   busy        out  1  high whenever the FSM is not IDLE
//   illegal     out  1  pulses with valid for opcodes 4'hE/4'hF
//   overrun     out  1  sticky: go seen while busy, cleared only by reset
//   state_dbg   out  2  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: go is a single-cycle request and is accepted only in IDLE when
// abort is low. Exactly one valid pulse answers every accepted request unless
// an abort cancels it. A new go is legal from the cycle after valid onward.
module fpu_scheduler #(
    parameter int CNT_W      = 5,
    parameter int LAT_ADDSUB = 2,
    parameter int LAT_MUL    = 2,
    parameter int LAT_DIV    = 10,
    parameter int LAT_SQRT   = 12,
    parameter int LAT_CVT    = 1,
    parameter int LAT_CMP    = 0,
    parameter int LAT_SGN    = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       go,
    input  logic [3:0] fpucontrol,
    input  logic       abort,
    output logic       start,
    output logic [2:0] unit_sel,
    output logic       res_we,
    output logic       valid,
    output logic       busy,
    output logic       illegal,
    output logic       overrun,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic             first_q, first_d;
    logic             overrun_q, overrun_d;

    function automatic logic [2:0] unit_of(input logic [3:0] op);
        logic [2:0] u;
        case (op)
            4'h0, 4'h1:               u = 3'd0;
            4'h2:                     u = 3'd1;
            4'h3:                     u = 3'd2;
            4'h4:                     u = 3'd3;
            4'h5, 4'h6:               u = 3'd4;
            4'h7, 4'h8, 4'h9:         u = 3'd5;
            4'hA, 4'hB, 4'hC, 4'hD:   u = 3'd6;
            default:                  u = 3'd0;
        endcase
        return u;
    endfunction

    function automatic logic [CNT_W-1:0] lat_of(input logic [2:0] u);
        logic [CNT_W-1:0] l;
        case (u)
            3'd0:    l = CNT_W'(LAT_ADDSUB);
            3'd1:    l = CNT_W'(LAT_MUL);
            3'd2:    l = CNT_W'(LAT_DIV);
            3'd3:    l = CNT_W'(LAT_SQRT);
            3'd4:    l = CNT_W'(LAT_CVT);
            3'd5:    l = CNT_W'(LAT_CMP);
            default: l = CNT_W'(LAT_SGN);
        endcase
        return l;
    endfunction

    logic in_illegal;
    logic op_illegal;
    assign in_illegal = (fpucontrol[3:1] == 3'b111);
    assign op_illegal = (op_q[3:1] == 3'b111);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            first_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            first_q   <= first_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        first_d   = first_q;
        // A request that arrives while an op is in flight is dropped but remembered.
        overrun_d = overrun_q | (go && (state_q != IDLE));
        case (state_q)
            IDLE: begin
                // abort beats a simultaneous go
                if (go && !abort) begin
                    op_d = fpucontrol;
                    if (in_illegal) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = lat_of(unit_of(fpucontrol));
                        first_d = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                first_d = 1'b0;
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // abort in the same cycle as the final count or the DONE cycle cancels the strobes.
    assign start     = (state_q == RUN) && first_q;
    assign res_we    = (state_q == RUN) && (cnt_q == '0) && !abort;
    assign valid     = (state_q == DONE) && !abort;
    assign illegal   = valid && op_illegal;
    assign busy      = (state_q != IDLE);
    assign unit_sel  = unit_of(op_q);
    assign overrun   = overrun_q;
    assign state_dbg = state_q;

endmodule
